// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word and opcode widths, the HALT opcode, the fetch FSM
// state encoding and the IF/ID field bundle used by the fetch stage.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [5:0]        opcode_t;

    // Opcode field (instr[31:26]) of the HALT instruction.
    localparam opcode_t OPC_HALT = 6'b111111;

    // Fetch FSM states. FETCH is encoded as zero so the reset value is all-zero.
    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        HALT_PEND = 2'd1,
        HALTED    = 2'd2
    } fetch_state_t;

    // IF/ID fields in the same order as pipe_reg_if (instr, incPC, pc).
    typedef struct packed {
        word_t instr;
        word_t incPC;
        word_t pc;
    } ifid_t;

    // Sequential next PC; plain 32-bit modulo add, wraps silently.
    function automatic word_t pc_plus4(input word_t p);
        return p + word_t'(4);
    endfunction

endpackage

// File: rtl/fetch_stage_pc_next_sel.sv
// Next-PC and IF/ID update selection for the fetch stage. Purely
// combinational so the priority order can be exercised on its own.
//
// Priority, highest first:
//   halt_wb > HALTED (absorbing) > ex_redirect > stall > id_redirect
//   > FETCH with ihit > anything else (bubble, PC holds).
// load_ifid_o and bubble_ifid_o are never both high; both low means the
// IF/ID register holds (stall).
module pc_next_sel
    import cpu_types_pkg::*;
(
    input  logic        halt_wb_i,
    input  logic        ex_redirect_i,
    input  logic [31:0] ex_target_i,
    input  logic        stall_i,
    input  logic        id_redirect_i,
    input  logic [31:0] id_target_i,
    input  logic        ihit_i,
    input  logic        is_halt_i,
    input  logic [1:0]  state_i,
    input  logic [31:0] pc_i,
    output logic [31:0] next_pc_o,
    output logic        load_ifid_o,
    output logic        bubble_ifid_o
);

    // Priority mux; defaults describe "hold everything".
    always_comb begin
        next_pc_o     = pc_i;
        load_ifid_o   = 1'b0;
        bubble_ifid_o = 1'b0;
        if (halt_wb_i) begin
            bubble_ifid_o = 1'b1;
        end else if (state_i == HALTED) begin
            bubble_ifid_o = 1'b1;
        end else if (ex_redirect_i) begin
            next_pc_o     = ex_target_i;
            bubble_ifid_o = 1'b1;
        end else if (stall_i) begin
            // Hold PC and IF/ID; a pending ID jump re-presents after the stall.
            next_pc_o     = pc_i;
        end else if (id_redirect_i) begin
            // Delay slot is squashed: any concurrent ihit is dropped.
            next_pc_o     = id_target_i;
            bubble_ifid_o = 1'b1;
        end else if ((state_i == FETCH) && ihit_i) begin
            load_ifid_o   = 1'b1;
            // Never fetch past a HALT: PC stays on the HALT word.
            next_pc_o     = is_halt_i ? pc_i : pc_plus4(pc_i);
        end else begin
            bubble_ifid_o = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the icache request and
// produces the IF/ID register (instr, incPC, pc, valid). Handles stalls,
// ID/EX redirects and HALT fetch/retirement.
//
// Icache handshake: iREN is held high in FETCH with iaddr stable until a
// cycle with ihit; the word on iload is consumed only on a rising edge where
// iREN && ihit and no higher-priority event (halt_wb, ex_redirect, stall,
// id_redirect) is present. iREN drops asynchronously while nRST is low.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT  = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPC = OPC_HALT
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        stall,
    input  logic        id_redirect,
    input  logic [31:0] id_target,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    input  logic        halt_wb,
    output logic [31:0] instr,
    output logic [31:0] incPC,
    output logic [31:0] pc,
    output logic        valid,
    output logic        halted,
    output logic [1:0]  state_dbg
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    ifid_t        ifid_q, ifid_d;
    logic         valid_q, valid_d;
    logic         halted_q, halted_d;

    logic         is_halt;
    word_t        next_pc;
    logic         load_ifid;
    logic         bubble_ifid;

    assign is_halt = (iload[31:26] == HALT_OPC);

    pc_next_sel u_pc_next_sel (
        .halt_wb_i     (halt_wb),
        .ex_redirect_i (ex_redirect),
        .ex_target_i   (ex_target),
        .stall_i       (stall),
        .id_redirect_i (id_redirect),
        .id_target_i   (id_target),
        .ihit_i        (ihit),
        .is_halt_i     (is_halt),
        .state_i       (state_q),
        .pc_i          (pc_q),
        .next_pc_o     (next_pc),
        .load_ifid_o   (load_ifid),
        .bubble_ifid_o (bubble_ifid)
    );

    // FSM next state; same priority order as the next-PC mux.
    always_comb begin
        state_d = state_q;
        if (halt_wb) begin
            state_d = HALTED;
        end else if (state_q == HALTED) begin
            state_d = HALTED;
        end else if (ex_redirect) begin
            state_d = FETCH;
        end else if (stall) begin
            state_d = state_q;
        end else if (id_redirect) begin
            state_d = FETCH;
        end else if ((state_q == FETCH) && ihit && is_halt) begin
            state_d = HALT_PEND;
        end
    end

    // Next values for PC, IF/ID fields and the sticky halted flag.
    always_comb begin
        pc_d     = next_pc;
        ifid_d   = ifid_q;
        valid_d  = valid_q;
        halted_d = halted_q | (state_d == HALTED);
        if (load_ifid) begin
            ifid_d.instr = iload;
            ifid_d.incPC = pc_plus4(pc_q);
            ifid_d.pc    = pc_q;
            valid_d      = 1'b1;
        end else if (bubble_ifid) begin
            ifid_d  = '0;
            valid_d = 1'b0;
        end
    end

    // State, PC and IF/ID registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= FETCH;
            pc_q     <= PC_INIT;
            ifid_q   <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ifid_q   <= ifid_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    // Request is decoded from state; gating with nRST abandons a pending miss.
    assign iREN      = (state_q == FETCH) && nRST;
    assign iaddr     = pc_q;
    assign instr     = ifid_q.instr;
    assign incPC     = ifid_q.incPC;
    assign pc        = ifid_q.pc;
    assign valid     = valid_q;
    assign halted    = halted_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector tables applied one clock each,
// outputs checked 1 ns after the rising edge, plus hand-written reset
// sequences (sticky-halt release, asynchronous reset during a miss).
module tb_fetch_stage;

    typedef struct {
        logic        ihit;
        logic [31:0] iload;
        logic        stall;
        logic        idr;
        logic [31:0] idt;
        logic        exr;
        logic [31:0] ext;
        logic        hwb;
        logic        e_iren;
        logic [31:0] e_iaddr;
        logic [31:0] e_instr;
        logic [31:0] e_inc;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        e_halted;
    } vec_t;

    logic        CLK;
    logic        nRST;
    logic        ihit;
    logic [31:0] iload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        stall;
    logic        id_redirect;
    logic [31:0] id_target;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic        halt_wb;
    logic [31:0] instr;
    logic [31:0] incPC;
    logic [31:0] pc;
    logic        valid;
    logic        halted;
    logic [1:0]  state_dbg;

    int checks;
    int failures;

    vec_t vecs_a[$];
    vec_t vecs_b[$];

    fetch_stage dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .iload       (iload),
        .iREN        (iREN),
        .iaddr       (iaddr),
        .stall       (stall),
        .id_redirect (id_redirect),
        .id_target   (id_target),
        .ex_redirect (ex_redirect),
        .ex_target   (ex_target),
        .halt_wb     (halt_wb),
        .instr       (instr),
        .incPC       (incPC),
        .pc          (pc),
        .valid       (valid),
        .halted      (halted),
        .state_dbg   (state_dbg)
    );

    // Clock and watchdog.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    function automatic vec_t mk(
        input logic ihit_v, input logic [31:0] iload_v, input logic stall_v,
        input logic idr_v, input logic [31:0] idt_v, input logic exr_v,
        input logic [31:0] ext_v, input logic hwb_v, input logic e_iren_v,
        input logic [31:0] e_iaddr_v, input logic [31:0] e_instr_v,
        input logic [31:0] e_inc_v, input logic [31:0] e_pc_v,
        input logic e_valid_v, input logic e_halted_v);
        vec_t v;
        v.ihit = ihit_v;     v.iload = iload_v;   v.stall = stall_v;
        v.idr = idr_v;       v.idt = idt_v;       v.exr = exr_v;
        v.ext = ext_v;       v.hwb = hwb_v;       v.e_iren = e_iren_v;
        v.e_iaddr = e_iaddr_v; v.e_instr = e_instr_v; v.e_inc = e_inc_v;
        v.e_pc = e_pc_v;     v.e_valid = e_valid_v; v.e_halted = e_halted_v;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        ihit = 1'b0; iload = 32'h0; stall = 1'b0;
        id_redirect = 1'b0; id_target = 32'h0;
        ex_redirect = 1'b0; ex_target = 32'h0; halt_wb = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic e_iren,
        input logic [31:0] e_iaddr, input logic [31:0] e_instr,
        input logic [31:0] e_inc, input logic [31:0] e_pc,
        input logic e_valid, input logic e_halted);
        chk({tag, ".iREN"},   {31'h0, iREN},   {31'h0, e_iren});
        chk({tag, ".iaddr"},  iaddr,           e_iaddr);
        chk({tag, ".instr"},  instr,           e_instr);
        chk({tag, ".incPC"},  incPC,           e_inc);
        chk({tag, ".pc"},     pc,              e_pc);
        chk({tag, ".valid"},  {31'h0, valid},  {31'h0, e_valid});
        chk({tag, ".halted"}, {31'h0, halted}, {31'h0, e_halted});
    endtask

    // Drive one vector, clock it in, check 1 ns after the edge.
    task automatic run_vec(input string tag, input vec_t v);
        ihit = v.ihit; iload = v.iload; stall = v.stall;
        id_redirect = v.idr; id_target = v.idt;
        ex_redirect = v.exr; ex_target = v.ext; halt_wb = v.hwb;
        @(posedge CLK);
        #1;
        check_outputs(tag, v.e_iren, v.e_iaddr, v.e_instr, v.e_inc,
                      v.e_pc, v.e_valid, v.e_halted);
    endtask

    // Hold reset across an edge, check cleared state, release mid-low-phase.
    task automatic do_reset(input string tag);
        drive_idle();
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        check_outputs({tag, ".in_reset"}, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk({tag, ".state"}, {30'h0, state_dbg}, 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        check_outputs({tag, ".released"}, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        nRST     = 1'b1;
        drive_idle();

        //            ihit iload          st idr idt    exr ext           hwb  iren iaddr         instr          incPC         pc            v  h
        // Sequential hits from reset.
        vecs_a.push_back(mk(1, 32'h2001_0005, 0, 0, 32'h0,  0, 32'h0,        0,   1, 32'h4,        32'h2001_0005, 32'h4,        32'h0,        1, 0));
        vecs_a.push_back(mk(1, 32'h2002_0003, 0, 0, 32'h0,  0, 32'h0,        0,   1, 32'h8,        32'h2002_0003, 32'h8,        32'h4,        1, 0));
        // Three-cycle miss at PC=8: address held, bubbles.
        vecs_a.push_back(mk(0, 32'h0,         0, 0, 32'h0,  0, 32'h0,        0,   1, 32'h8,        32'h0,         32'h0,        32'h0,        0, 0));
        vecs_a.push_back(mk(0, 32'h0,         0, 0, 32'h0,  0, 32'h0,        0,   1, 32'h8,        32'h0,         32'h0,        32'h0,        0, 0));
        vecs_a.push_back(mk(0, 32'h0,         0, 0, 32'h0,  0, 32'h0,        0,   1, 32'h8,        32'h0,         32'h0,        32'h0,        0, 0));
        vecs_a.push_back(mk(1, 32'h2003_0007, 0, 0, 32'h0,  0, 32'h0,        0,   1, 32'hC,        32'h2003_0007, 32'hC,        32'h8,        1, 0));
        vecs_a.push_back(mk(1, 32'h2004_0001, 0, 0, 32'h0,  0, 32'h0,        0,   1, 32'h10,       32'h2004_0001, 32'h10,       32'hC,        1, 0));
        // Stall at PC=16 for two cycles; concurrent id_redirect ignored.
        vecs_a.push_back(mk(1, 32'hDEAD_BEEF, 1, 1, 32'h40, 0, 32'h0,        0,   1, 32'h10,       32'h2004_0001, 32'h10,       32'hC,        1, 0));
        vecs_a.push_back(mk(1, 32'hDEAD_BEEF, 1, 1, 32'h40, 0, 32'h0,        0,   1, 32'h10,       32'h2004_0001, 32'h10,       32'hC,        1, 0));
        // ex_redirect beats stall, id_redirect and ihit.
        vecs_a.push_back(mk(1, 32'h1111_1111, 1, 1, 32'h80, 1, 32'h100,      0,   1, 32'h100,      32'h0,         32'h0,        32'h0,        0, 0));
        vecs_a.push_back(mk(1, 32'h2005_0002, 0, 0, 32'h0,  0, 32'h0,        0,   1, 32'h104,      32'h2005_0002, 32'h104,      32'h100,      1, 0));
        // id_redirect squashes the concurrent hit.
        vecs_a.push_back(mk(1, 32'h2222_2222, 0, 1, 32'h20, 0, 32'h0,        0,   1, 32'h20,       32'h0,         32'h0,        32'h0,        0, 0));
        vecs_a.push_back(mk(1, 32'h2006_0000, 0, 0, 32'h0,  0, 32'h0,        0,   1, 32'h24,       32'h2006_0000, 32'h24,       32'h20,       1, 0));
        // HALT fetched at 0x24: PC holds, iREN drops, then bubbles.
        vecs_a.push_back(mk(1, 32'hFC00_0000, 0, 0, 32'h0,  0, 32'h0,        0,   0, 32'h24,       32'hFC00_0000, 32'h28,       32'h24,       1, 0));
        vecs_a.push_back(mk(1, 32'h3333_3333, 0, 0, 32'h0,  0, 32'h0,        0,   0, 32'h24,       32'h0,         32'h0,        32'h0,        0, 0));
        // ex_redirect cancels HALT_PEND and resumes at 0x50.
        vecs_a.push_back(mk(0, 32'h0,         0, 0, 32'h0,  1, 32'h50,       0,   1, 32'h50,       32'h0,         32'h0,        32'h0,        0, 0));
        vecs_a.push_back(mk(1, 32'h2007_0000, 0, 0, 32'h0,  0, 32'h0,        0,   1, 32'h54,       32'h2007_0000, 32'h54,       32'h50,       1, 0));
        // Second HALT, then retirement (halt_wb dominates a redirect).
        vecs_a.push_back(mk(1, 32'hFC00_0000, 0, 0, 32'h0,  0, 32'h0,        0,   0, 32'h54,       32'hFC00_0000, 32'h58,       32'h54,       1, 0));
        vecs_a.push_back(mk(0, 32'h0,         0, 0, 32'h0,  0, 32'h0,        0,   0, 32'h54,       32'h0,         32'h0,        32'h0,        0, 0));
        vecs_a.push_back(mk(0, 32'h0,         0, 0, 32'h0,  1, 32'h200,      1,   0, 32'h54,       32'h0,         32'h0,        32'h0,        0, 1));
        // HALTED absorbs redirects and hits.
        vecs_a.push_back(mk(1, 32'h2001_0005, 0, 0, 32'h0,  1, 32'h300,      0,   0, 32'h54,       32'h0,         32'h0,        32'h0,        0, 1));
        vecs_a.push_back(mk(1, 32'h2001_0005, 0, 1, 32'h60, 0, 32'h0,        0,   0, 32'h54,       32'h0,         32'h0,        32'h0,        0, 1));

        // PC wrap at 0xFFFFFFFC, then a valid fetch at 0x80.
        vecs_b.push_back(mk(0, 32'h0,         0, 0, 32'h0,  1, 32'hFFFF_FFFC, 0,  1, 32'hFFFF_FFFC, 32'h0,        32'h0,        32'h0,        0, 0));
        vecs_b.push_back(mk(1, 32'h2008_0000, 0, 0, 32'h0,  0, 32'h0,        0,   1, 32'h0,        32'h2008_0000, 32'h0,        32'hFFFF_FFFC, 1, 0));
        vecs_b.push_back(mk(0, 32'h0,         0, 0, 32'h0,  1, 32'h80,       0,   1, 32'h80,       32'h0,         32'h0,        32'h0,        0, 0));
        vecs_b.push_back(mk(1, 32'h2009_0000, 0, 0, 32'h0,  0, 32'h0,        0,   1, 32'h84,       32'h2009_0000, 32'h84,       32'h80,       1, 0));

        do_reset("reset0");

        for (int i = 0; i < vecs_a.size(); i++) begin
            run_vec($sformatf("a%0d", i), vecs_a[i]);
        end

        // Halted is sticky across idle cycles until reset.
        drive_idle();
        repeat (3) @(posedge CLK);
        #1;
        check_outputs("halt_sticky", 1'b0, 32'h54, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);

        do_reset("reset1");

        for (int i = 0; i < vecs_b.size(); i++) begin
            run_vec($sformatf("b%0d", i), vecs_b[i]);
        end

        // Miss pending at 0x84, then asynchronous reset between clock edges.
        ihit = 1'b0;
        #2;
        nRST = 1'b0;
        #1;
        check_outputs("async_rst", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("async_rst.state", {30'h0, state_dbg}, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        chk("async_rst.release_iren", {31'h0, iREN}, 32'h1);
        run_vec("post_rst", mk(1, 32'h200A_0000, 0, 0, 32'h0, 0, 32'h0, 0,
                               1, 32'h4, 32'h200A_0000, 32'h4, 32'h0, 1, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core.
- Owns the PC register and drives the icache request (iREN/iaddr).
- Produces the IF/ID pipeline-register fields (instr, incPC, pc, valid) consumed by the decode stage.
- Handles stalls, redirects from ID and EX, and halt-instruction fetch/retirement.

Parameters:
PC_INIT, 32'h00000000, PC value loaded on reset.
HALT_OPC, 6'b111111, opcode field (instr[31:26]) identifying HALT.

Ports:
CLK  in  1  system clock, rising edge.
nRST  in  1  asynchronous active-low reset.
ihit  in  1  icache returns valid iload this cycle.
iload  in  32  instruction word from icache.
iREN  out  1  icache read enable.
iaddr  out  32  icache address (equals current PC).
stall  in  1  hazard unit: hold PC and IF/ID outputs.
id_redirect  in  1  J/JAL resolved in ID.
id_target  in  32  ID jump target.
ex_redirect  in  1  taken branch or JR resolved in EX.
ex_target  in  32  EX redirect target.
halt_wb  in  1  HALT instruction retired in WB.
instr  out  32  IF/ID instruction; 0 (nop) on a bubble.
incPC  out  32  IF/ID pc+4.
pc  out  32  IF/ID PC of instr.
valid  out  1  IF/ID slot holds a real instruction.
halted  out  1  core halted (sticky until reset).

Behaviour:
Reset (nRST low, asynchronous):
- PC=PC_INIT; instr/incPC/pc=0; valid=0; halted=0; state=FETCH.
- Deassertion is synchronised externally; the first fetch starts the cycle after release.

States:
- FETCH: iREN=1.
- HALT_PEND: HALT fetched but not retired; iREN=0.
- HALTED: absorbing; iREN=0; halted=1.

Outputs and timing:
- iaddr=PC combinationally in all states.
- All outputs are registered, except iREN/iaddr, which are decoded from state/PC.

Per-cycle priority, evaluated at the rising edge:
1. halt_wb: state=HALTED, IF/ID becomes a bubble. Dominates everything, including redirects.
2. ex_redirect: PC=ex_target, IF/ID becomes a bubble, state=FETCH (cancels HALT_PEND). Overrides stall and id_redirect. A concurrent ihit is discarded.
3. stall (no ex_redirect): PC, IF/ID and state all hold. id_redirect is ignored, since the jump re-presents after the stall.
4. id_redirect: PC=id_target, IF/ID becomes a bubble, state=FETCH. Any concurrent ihit is discarded (the delay slot is squashed).
5. FETCH with ihit:
   - IF/ID = {iload, PC+4, PC, valid=1}; PC=PC+4.
   - If iload[31:26]==HALT_OPC: state=HALT_PEND and PC holds (no fetch beyond HALT).
6. FETCH without ihit: IF/ID becomes a bubble; PC holds; iREN stays high and iaddr stays stable until ihit.
7. HALT_PEND with none of the above: IF/ID becomes a bubble; PC holds.

Definitions and boundary rules:
- A bubble is instr=0, valid=0. incPC and pc also clear to 0.
- PC+4 is 32-bit modulo: 32'hFFFFFFFC wraps to 0, with no flag.
- Redirect targets are used unmodified; no alignment check.
- halted rises one cycle after halt_wb and stays high until nRST.
- A reset mid-miss (ihit pending) abandons the request; iREN deasserts asynchronously with nRST.

Decomposition:
- cpu_types_pkg owns word_t, WORD_W, opcode_t and the HALT opcode constant. HALT_OPC defaults from that constant.
- Add the enum fetch_state_t {FETCH, HALT_PEND, HALTED} to the same package for bench visibility.
- One sub-module, pc_next_sel: combinational next-PC/priority mux. Inputs are the redirects, stall, ihit, state and PC; outputs are next_pc, load_ifid and bubble_ifid. It is unit-testable in isolation.
- The IF/ID field bundle stays compatible with pipe_reg_if (instr, incPC, pc).

Test Plan:
1. Reset release, ihit=1 every cycle, iload = 32'h20010005, 32'h20020003, ... -> iaddr = 0, 4, 8; IF/ID pc = 0, 4 with incPC = 4, 8; valid=1 each cycle after the first edge.
2. Miss: ihit=0 for 3 cycles at PC=8 -> iaddr held at 8, iREN=1, valid=0 for 3 cycles. Then ihit=1 -> instr latched with pc=8, and PC becomes 12.
3. Stall at PC=16 with ihit=1 for 2 cycles -> PC, instr, pc and valid are unchanged for both cycles. A concurrent id_redirect to 32'h40 is ignored.
4. ex_redirect with ex_target=32'h100 while stall=1, id_redirect=1 (id_target=32'h80) and ihit=1 -> next PC=32'h100, valid=0, instr=0. The next ihit latches pc=32'h100.
5. Fetch iload=32'hFC000000 at PC=32'h24 -> valid=1, pc=32'h24, iREN=0 next cycle, PC held at 32'h24. A later ex_redirect to 32'h50 resumes fetch at 32'h50. Repeat without the redirect and with halt_wb=1 -> halted=1 and iREN=0 permanently; nRST pulse restores PC=PC_INIT and halted=0.
6. PC=32'hFFFFFFFC with ihit=1 -> incPC=0 and next iaddr=0; nRST asserted mid-miss -> outputs cleared immediately, without waiting for a clock edge.
